// File: rtl/fir_seq_ctrl.sv
`timescale 1ns/1ps
// Sample-rate sequencer for a 12-tap transposed FIR (4 groups x 3 coefficients), double-buffered coefficients.
// Enables are registered, one cycle after the tick; iHold freezes the sequence. Macro FIR_SEQ_CTRL_STATS_EN adds counters.
module fir_seq_ctrl #(
    parameter int SAMPLE_DIV = 40,
    parameter int COEFF_W    = 16
) (
    input  logic               iClk_12M,
    input  logic               iRsn,
    input  logic               iHold,
    input  logic               iCoeffWr,
    input  logic [3:0]         iCoeffAddr,
    input  logic [COEFF_W-1:0] iCoeffData,
    input  logic               iCoeffCommit,
    input  logic               iClrStatus,
    output logic               oEnSample_300k,
    output logic [3:0]         oEnMul,
    output logic               oEnAdd,
    output logic               oEnAcc,
    output logic [COEFF_W-1:0] oCoeff1,
    output logic [COEFF_W-1:0] oCoeff2,
    output logic [COEFF_W-1:0] oCoeff3,
    output logic               oCommitPend,
`ifdef FIR_SEQ_CTRL_STATS_EN
    output logic [15:0]        oSampleCnt,
    output logic [7:0]         oDropCnt,
`endif
    output logic               oOverrun
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {IDLE, MUL, ADD, ACC} state_t;

    state_t              state, state_nxt;
    logic [1:0]          grp, grp_nxt, sel_grp;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick, drop, swap, load_coeff;
    logic [3:0]          en_mul_nxt;
    logic                en_add_nxt, en_acc_nxt;
    logic [3:0]          base;
    logic [COEFF_W-1:0]  coeff1_nxt, coeff2_nxt, coeff3_nxt;
    logic [COEFF_W-1:0]  shadow [12];
    logic [COEFF_W-1:0]  active [12];

    assign tick = oEnSample_300k;

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            div_cnt        <= '0;
            oEnSample_300k <= 1'b0;
        end else begin
            oEnSample_300k <= (div_cnt == DIV_LAST);
            div_cnt        <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        grp_nxt    = grp;
        en_mul_nxt = '0;
        en_add_nxt = 1'b0;
        en_acc_nxt = 1'b0;
        load_coeff = 1'b0;
        sel_grp    = 2'd0;
        swap       = 1'b0;
        drop       = tick && (state != IDLE);
        if (!iHold) begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state_nxt  = MUL;
                        grp_nxt    = 2'd0;
                        en_mul_nxt = 4'b0001;
                        load_coeff = 1'b1;
                        swap       = oCommitPend;
                    end
                end
                MUL: begin
                    if (grp == 2'd3) begin
                        state_nxt  = ADD;
                        en_add_nxt = 1'b1;
                    end else begin
                        grp_nxt    = grp + 2'd1;
                        en_mul_nxt = 4'b0001 << grp_nxt;
                        load_coeff = 1'b1;
                        sel_grp    = grp_nxt;
                    end
                end
                ADD: begin
                    state_nxt  = ACC;
                    en_acc_nxt = 1'b1;
                end
                ACC:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // On a swapping start the first triple must come from the bank that becomes active on this edge.
    always_comb begin
        base       = {2'b00, sel_grp} * 4'd3;
        coeff1_nxt = swap ? shadow[base]         : active[base];
        coeff2_nxt = swap ? shadow[base + 4'd1]  : active[base + 4'd1];
        coeff3_nxt = swap ? shadow[base + 4'd2]  : active[base + 4'd2];
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state       <= IDLE;
            grp         <= 2'd0;
            oEnMul      <= '0;
            oEnAdd      <= 1'b0;
            oEnAcc      <= 1'b0;
            oCoeff1     <= '0;
            oCoeff2     <= '0;
            oCoeff3     <= '0;
            oCommitPend <= 1'b0;
            oOverrun    <= 1'b0;
        end else begin
            state  <= state_nxt;
            grp    <= grp_nxt;
            oEnMul <= en_mul_nxt;
            oEnAdd <= en_add_nxt;
            oEnAcc <= en_acc_nxt;
            if (load_coeff) begin
                oCoeff1 <= coeff1_nxt;
                oCoeff2 <= coeff2_nxt;
                oCoeff3 <= coeff3_nxt;
            end
            oCommitPend <= (oCommitPend && !swap) || iCoeffCommit;
            if (drop)
                oOverrun <= 1'b1;
            else if (iClrStatus)
                oOverrun <= 1'b0;
        end
    end

    // Swap copies the pre-edge shadow; a coincident write lands in shadow only.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < 12; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (swap) begin
                for (int i = 0; i < 12; i++)
                    active[i] <= shadow[i];
            end
            if (iCoeffWr && (iCoeffAddr < 4'd12))
                shadow[iCoeffAddr] <= iCoeffData;
        end
    end

`ifdef FIR_SEQ_CTRL_STATS_EN
    logic start;
    assign start = tick && (state == IDLE) && !iHold;

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            oSampleCnt <= '0;
            oDropCnt   <= '0;
        end else if (iClrStatus) begin
            oSampleCnt <= '0;
            oDropCnt   <= '0;
        end else begin
            if (start)
                oSampleCnt <= oSampleCnt + 16'd1;
            if (drop && (oDropCnt != 8'hFF))
                oDropCnt <= oDropCnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer for the 12-tap transposed FIR datapath. The datapath is built as 4 multiplier groups of 3 coefficients each.
- Generates the 300 kHz sample strobe from the 12 MHz clock.
- Once per sample, steps one-hot multiplier enables, then the add and accumulate enables, while muxing the active coefficient triple onto the datapath.
- Holds a double-buffered coefficient bank: host writes go to a shadow copy, which is swapped in atomically at a sample boundary.

Parameters:
SAMPLE_DIV, 40, clock cycles per sample period (12 MHz / 40 = 300 kHz); legal range 8..1023
COEFF_W, 16, coefficient width in bits

Ports:
iClk_12M  in  1  system clock
iRsn  in  1  asynchronous active-low reset
iHold  in  1  datapath backpressure; freezes the sequencer
iCoeffWr  in  1  shadow-bank write strobe
iCoeffAddr  in  4  tap index 0..11
iCoeffData  in  COEFF_W  signed coefficient
iCoeffCommit  in  1  request shadow->active swap at next sample tick
iClrStatus  in  1  clears sticky status
oEnSample_300k  out  1  one-cycle sample strobe
oEnMul  out  4  one-hot multiplier-group enable
oEnAdd  out  1  adder-stage enable
oEnAcc  out  1  accumulate/output enable
oCoeff1  out  COEFF_W  active coefficient 3*g+0
oCoeff2  out  COEFF_W  active coefficient 3*g+1
oCoeff3  out  COEFF_W  active coefficient 3*g+2
oCommitPend  out  1  commit requested, swap not yet done
oOverrun  out  1  sticky: sample tick arrived while the sequencer was busy

Behaviour:
- Reset (async, iRsn=0):
  - All outputs 0.
  - Divider count 0, FSM IDLE, group index 0.
  - Both coefficient banks cleared to 0.
  - A mid-sequence reset aborts immediately; no enable is emitted after iRsn falls.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - oEnSample_300k is registered and high for exactly one cycle per wrap.
  - First pulse appears in cycle SAMPLE_DIV after reset release.
  - iHold does not affect the divider.
- FSM states: IDLE, MUL, ADD, ACC.
  - IDLE: on a tick, go to MUL with g=0. If oCommitPend=1 (pre-edge value), copy shadow->active on that same edge and clear oCommitPend.
  - MUL: oEnMul = 1<<g. oCoeff1/2/3 = active[3g], active[3g+1], active[3g+2]. g increments each cycle; after g=3, go to ADD.
  - ADD: oEnAdd=1 for one cycle, then go to ACC.
  - ACC: oEnAcc=1 for one cycle, then go to IDLE.
  - All enables are registered and mutually exclusive.
  - Unstalled sequence is 6 cycles: oEnMul 0001, 0010, 0100, 1000, then ADD, then ACC. The first enable appears the cycle after the tick.
- iHold=1:
  - State and g are frozen; oEnMul, oEnAdd and oEnAcc are forced to 0; oCoeff* keep their values.
  - Sequencing resumes where it stopped once iHold=0.
- Overrun:
  - A tick in any state other than IDLE sets oOverrun and the tick is dropped; no restart.
  - oOverrun holds until iClrStatus. If set and clear coincide, set wins.
- Outside MUL: oCoeff* hold their last value (0 after reset).
- Shadow writes:
  - iCoeffWr with addr 0..11 writes shadow[addr] on that edge, in any state.
  - Addr 12..15 is ignored.
- Commit:
  - iCoeffCommit sets oCommitPend; a repeat while pending has no effect.
  - If commit coincides with an IDLE tick, the swap is deferred to the next tick.
  - If a write coincides with a swap, active receives the pre-edge shadow and the write lands in shadow only.
  - The active bank never changes mid-sequence.

Optional Feature:
FIR_SEQ_CTRL_STATS_EN
- Defined: adds output oSampleCnt[15:0], which increments (wrapping) on every started sequence, and output oDropCnt[7:0], which counts dropped ticks and saturates at 255. Both are cleared by reset and by iClrStatus.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release with iHold=0: oEnSample_300k pulses in cycles 40, 80, 120. After each pulse, oEnMul runs 1,2,4,8, then oEnAdd, then oEnAcc, each for exactly one cycle; oOverrun stays 0.
- Write shadow[0..11]=0x0001..0x000C, commit, next tick: during oEnMul=0100, oCoeff1/2/3 = 0x0007/0x0008/0x0009. Before the tick, active is 0.
- Commit asserted on the same cycle as a tick: the current sequence uses the old bank; the swap occurs at the following tick; oCommitPend stays 1 in between.
- iHold=1 for 50 cycles starting during oEnMul=0010: enables are 0 during the hold, the tick during the hold sets oOverrun, and on release the sequence resumes at 0100. After iClrStatus, oOverrun=0.
- Assert iRsn=0 while oEnMul=0100: all outputs go to 0 asynchronously. After release, the first pulse is in cycle 40 and the coefficients read 0.
- Write to addr 13 followed by a commit: active taps 0..11 are unchanged versus the prior shadow contents.
